slice_ram_writer: RTL and testbench

- Double-buffered (ping-pong) slice RAM directly upstream of the framebuffer stage.
- Accepts a raster pixel stream and fills one bank of DEPTH x 24-bit words.
- Serves the other bank to the framebuffer's ram_addr/ram_data read port.
- Swaps banks on framebuffer EOR and emits the SOF pulse that restarts the framebuffer.

---
 rtl/spirose_pkg.sv | 16 +
 rtl/slice_ram_dp.sv | 29 ++
 rtl/slice_ram_writer.sv | 171 +++++++++++++++++
 tb/tb_slice_ram_writer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/spirose_pkg.sv
// rtl/spirose_pkg.sv - shared pixel and slice types for the slice RAM path
package spirose_pkg;

   localparam int PIX_W        = 24;
   localparam int SLICE_DEPTH  = 128;
   localparam int SLICE_ADDR_W = 7;

   typedef logic [PIX_W-1:0] rgb_t;

   typedef enum logic [1:0] {
      WR_WAIT_SOF,
      WR_FILL,
      WR_FULL
   } wr_state_t;

endpackage

// File: rtl/slice_ram_dp.sv
// rtl/slice_ram_dp.sv - simple dual-port RAM holding both slice banks
module slice_ram_dp #(
   parameter int DEPTH  = 128,
   parameter int DATA_W = 24,
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W:0]   waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W:0]   raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2*DEPTH];

   // write port; contents are deliberately not reset so this maps onto block RAM
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // registered read port
   always_ff @(posedge clk) begin
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/slice_ram_writer.sv
// rtl/slice_ram_writer.sv - ping-pong slice RAM feeding the framebuffer (option: SLICE_RAM_TEST_PATTERN_EN)
module slice_ram_writer
   import spirose_pkg::*;
#(
   parameter int DEPTH  = SLICE_DEPTH,
   parameter int DATA_W = PIX_W,
   parameter int ADDR_W = SLICE_ADDR_W
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              pix_valid,
   input  logic [DATA_W-1:0] pix_data,
   input  logic              pix_sof,
   input  logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   input  logic              EOR,
   output logic              SOF,
   output logic [15:0]       drop_cnt,
   output logic              resync
`ifdef SLICE_RAM_TEST_PATTERN_EN
   ,
   input  logic              tp_sel
`endif
);

   wr_state_t         wr_state, wr_state_n;
   logic [ADDR_W-1:0] wr_addr, wr_addr_n, wr_waddr;
   logic              wr_en;
   logic              wr_bank, rd_bank;
   logic              rd_active, eor_pending;
   logic              swap, resync_n, drop;
   logic              rd_valid;
   logic [DATA_W-1:0] rdata;
   logic [DATA_W-1:0] ram_word;

   // a full write bank is handed over once the reader is idle or has finished its bank
   assign swap = (wr_state == WR_FULL) && (!rd_active || EOR || eor_pending);

   // write FSM state register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_state <= WR_WAIT_SOF;
         wr_addr  <= '0;
      end else begin
         wr_state <= wr_state_n;
         wr_addr  <= wr_addr_n;
      end
   end

   // write FSM next state, RAM write strobe, drop and resync detection
   always_comb begin
      wr_state_n = wr_state;
      wr_addr_n  = wr_addr;
      wr_en      = 1'b0;
      wr_waddr   = wr_addr;
      resync_n   = 1'b0;
      drop       = 1'b0;
      case (wr_state)
         WR_WAIT_SOF: begin
            if (pix_valid && pix_sof) begin
               wr_en      = 1'b1;
               wr_waddr   = '0;
               wr_addr_n  = ADDR_W'(1);
               wr_state_n = WR_FILL;
            end
         end
         WR_FILL: begin
            if (pix_valid) begin
               wr_en = 1'b1;
               if (pix_sof) begin
                  // restart the slice; the partial one is simply overwritten
                  wr_waddr  = '0;
                  wr_addr_n = ADDR_W'(1);
                  resync_n  = 1'b1;
               end else begin
                  wr_addr_n = wr_addr + ADDR_W'(1);
                  if (wr_addr == ADDR_W'(DEPTH - 1)) begin
                     wr_state_n = WR_FULL;
                  end
               end
            end
         end
         WR_FULL: begin
            drop = pix_valid;
            if (swap) begin
               wr_state_n = WR_WAIT_SOF;
            end
         end
         default: wr_state_n = WR_WAIT_SOF;
      endcase
   end

   // bank ownership, pending end-of-read and the SOF pulse
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_bank     <= 1'b0;
         rd_bank     <= 1'b0;
         rd_active   <= 1'b0;
         eor_pending <= 1'b0;
         SOF         <= 1'b0;
      end else begin
         SOF <= swap;
         if (swap) begin
            rd_bank     <= wr_bank;
            wr_bank     <= ~wr_bank;
            rd_active   <= 1'b1;
            eor_pending <= 1'b0;
         end else if (EOR && rd_active) begin
            eor_pending <= 1'b1;
         end
      end
   end

   // drop counter (saturating) and resync pulse
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         drop_cnt <= '0;
         resync   <= 1'b0;
      end else begin
         resync <= resync_n;
         if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end

   // tracks whether the RAM read register holds data from a live bank
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_active;
      end
   end

   slice_ram_dp #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr ({wr_bank, wr_waddr}),
      .wdata (pix_data),
      .raddr ({rd_bank, ram_addr}),
      .rdata (rdata)
   );

   assign ram_word = rd_valid ? rdata : '0;

`ifdef SLICE_RAM_TEST_PATTERN_EN
   logic              tp_act;
   logic [DATA_W-1:0] tp_word;

   // registered address-derived pattern, aligned with the RAM read latency
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         tp_act  <= 1'b0;
         tp_word <= '0;
      end else begin
         tp_act  <= tp_sel;
         tp_word <= DATA_W'({1'b0, ram_addr, ~{1'b0, ram_addr}, 8'h00});
      end
   end

   assign ram_data = tp_act ? tp_word : ram_word;
`else
   assign ram_data = ram_word;
`endif

endmodule

// File: tb/tb_slice_ram_writer.sv
// tb/tb_slice_ram_writer.sv - directed self-checking bench for slice_ram_writer
module tb_slice_ram_writer;

   logic        clk = 1'b0;
   logic        nrst;
   logic        pix_valid;
   logic [23:0] pix_data;
   logic        pix_sof;
   logic [6:0]  ram_addr;
   logic [23:0] ram_data;
   logic        EOR;
   logic        SOF;
   logic [15:0] drop_cnt;
   logic        resync;
`ifdef SLICE_RAM_TEST_PATTERN_EN
   logic        tp_sel;
`endif

   int checks   = 0;
   int failures = 0;
   int sof_seen = 0;
   int sof_mark;

   typedef struct {
      int          phase;
      logic [6:0]  addr;
      logic [23:0] exp;
   } rd_vec_t;

   rd_vec_t tab[16];

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (SOF === 1'b1) sof_seen++;
   end

   slice_ram_writer dut (
      .clk       (clk),
      .nrst      (nrst),
      .pix_valid (pix_valid),
      .pix_data  (pix_data),
      .pix_sof   (pix_sof),
      .ram_addr  (ram_addr),
      .ram_data  (ram_data),
      .EOR       (EOR),
      .SOF       (SOF),
      .drop_cnt  (drop_cnt),
      .resync    (resync)
`ifdef SLICE_RAM_TEST_PATTERN_EN
      ,
      .tp_sel    (tp_sel)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pixel(input int d, input logic s, input logic e);
      pix_valid = 1'b1;
      pix_data  = 24'(d);
      pix_sof   = s;
      EOR       = e;
      step();
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      EOR       = 1'b0;
   endtask

   task automatic fill(input int base, input int eor_at);
      for (int i = 0; i < 128; i++) pixel(base + i, i == 0, i == eor_at);
   endtask

   task automatic rd(input logic [6:0] a, input logic [23:0] e, input string nm);
      ram_addr = a;
      step();
      chk(nm, 32'(ram_data), 32'(e));
   endtask

   task automatic run_phase(input int p);
      for (int i = 0; i < 16; i++) begin
         if (tab[i].phase == p) rd(tab[i].addr, tab[i].exp, $sformatf("rd_p%0d_a%0d", p, tab[i].addr));
      end
   endtask

   initial begin
      tab[0]  = '{0, 7'd37,  24'd37};
      tab[1]  = '{0, 7'd0,   24'd0};
      tab[2]  = '{0, 7'd127, 24'd127};
      tab[3]  = '{1, 7'd0,   24'd1000};
      tab[4]  = '{1, 7'd37,  24'd1037};
      tab[5]  = '{2, 7'd60,  24'd2060};
      tab[6]  = '{2, 7'd59,  24'd2059};
      tab[7]  = '{2, 7'd61,  24'd2061};
      tab[8]  = '{3, 7'd0,   24'd3000};
      tab[9]  = '{3, 7'd127, 24'd3127};
      tab[10] = '{4, 7'd5,   24'd4005};
      tab[11] = '{5, 7'd10,  24'd6010};
      tab[12] = '{5, 7'd50,  24'd6050};
      tab[13] = '{5, 7'd100, 24'd6100};
      tab[14] = '{6, 7'd3,   24'd7003};
      tab[15] = '{9, 7'd0,   24'd0};

      nrst      = 1'b0;
      pix_valid = 1'b0;
      pix_data  = '0;
      pix_sof   = 1'b0;
      ram_addr  = '0;
      EOR       = 1'b0;
`ifdef SLICE_RAM_TEST_PATTERN_EN
      tp_sel    = 1'b0;
`endif
      idle(3);
      chk("rst_sof", 32'(SOF), 0);
      chk("rst_drop", 32'(drop_cnt), 0);
      chk("rst_resync", 32'(resync), 0);
      chk("rst_ram_data", 32'(ram_data), 0);
      nrst = 1'b1;
      step();

      // slice A: read side empty, swap follows the fill immediately
      sof_mark = sof_seen;
      fill(0, -1);
      chk("a_sof_swap_cycle", 32'(SOF), 0);
      step();
      chk("a_sof_pulse", 32'(SOF), 1);
      step();
      chk("a_sof_low", 32'(SOF), 0);
      chk("a_sof_count", 32'(sof_seen - sof_mark), 1);
      run_phase(0);

      // slice B: held until EOR
      sof_mark = sof_seen;
      fill(1000, -1);
      idle(5);
      chk("b_no_sof", 32'(sof_seen - sof_mark), 0);
      rd(7'd37, 24'd37, "b_old_bank");
      EOR = 1'b1;
      step();
      EOR = 1'b0;
      chk("b_sof_after_eor", 32'(SOF), 1);
      step();
      chk("b_sof_low", 32'(SOF), 0);
      run_phase(1);

      // slice C: EOR during fill becomes pending
      fill(2000, 60);
      chk("c_sof_swap_cycle", 32'(SOF), 0);
      step();
      chk("c_sof_pulse", 32'(SOF), 1);
      run_phase(2);

      // slice D: drops while full, then a pixel in the swap cycle
      fill(3000, -1);
      for (int i = 0; i < 5; i++) pixel(24'hABCDEF, 1'b0, 1'b0);
      chk("d_drop5", 32'(drop_cnt), 5);
      pixel(24'h123456, 1'b0, 1'b1);
      chk("d_sof_swap", 32'(SOF), 1);
      chk("d_drop6", 32'(drop_cnt), 6);
      run_phase(3);

      // slice E: EOR coincides with the final write
      fill(4000, 127);
      chk("e_sof_swap_cycle", 32'(SOF), 0);
      step();
      chk("e_sof_pulse", 32'(SOF), 1);
      run_phase(4);

      // slice F abandoned at pixel 50, slice G restarts
      for (int i = 0; i < 50; i++) pixel(5000 + i, i == 0, 1'b0);
      chk("f_no_resync", 32'(resync), 0);
      pixel(6000, 1'b1, 1'b0);
      chk("g_resync_pulse", 32'(resync), 1);
      for (int i = 1; i < 128; i++) begin
         pixel(6000 + i, 1'b0, 1'b0);
         if (i == 1) chk("g_resync_low", 32'(resync), 0);
      end
      EOR = 1'b1;
      step();
      EOR = 1'b0;
      chk("g_sof_pulse", 32'(SOF), 1);
      run_phase(5);

      // reset mid-fill
      for (int i = 0; i < 30; i++) pixel(9000 + i, i == 0, 1'b0);
      nrst = 1'b0;
      #1;
      chk("mr_sof", 32'(SOF), 0);
      chk("mr_drop", 32'(drop_cnt), 0);
      chk("mr_ram_data", 32'(ram_data), 0);
      step();
      nrst = 1'b1;
      step();
      sof_mark = sof_seen;
      for (int i = 0; i < 128; i++) pixel(8000 + i, 1'b0, 1'b0);
      idle(3);
      chk("mr_ignored_no_sof", 32'(sof_seen - sof_mark), 0);
      rd(7'd3, 24'd0, "mr_rd_empty");
      fill(7000, -1);
      step();
      chk("h_sof_pulse", 32'(SOF), 1);
      run_phase(6);

`ifdef SLICE_RAM_TEST_PATTERN_EN
      tp_sel = 1'b1;
      rd(7'h05, 24'h05FA00, "tp_addr5");
      rd(7'h7F, 24'h7F8000, "tp_addr7f");
      tp_sel = 1'b0;
      rd(7'd3, 24'd7003, "tp_off");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
